// File: rtl/osc_capture_buffer_if.sv
`default_nettype none
// ============================================================================
// Module   : osc_capture_buffer_if
// Summary  : sample stream input and column read-back bundle for the scope
// Revision : 1.0
// ============================================================================
interface osc_capture_buffer_if #(
    parameter int SAMPLE_W = 32,
    parameter int CHANNELS = 2
);
    localparam int c_ch_w = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    logic                         sample_valid;
    logic [CHANNELS*SAMPLE_W-1:0] sample_in;
    logic [c_ch_w-1:0]            ch_sel;
    logic [7:0]                   x;
    logic [31:0]                  y;
    logic                         y_sign;

    modport master (output sample_valid, sample_in, ch_sel, x, input  y, y_sign);
    modport slave  (input  sample_valid, sample_in, ch_sel, x, output y, y_sign);
endinterface
`default_nettype wire

// File: rtl/osc_capture_buffer.sv
`default_nettype none
// ============================================================================
// Module   : osc_capture_buffer
// Summary  : decimating, scaling, triggered circular frame capture for a scope
// Revision : 1.0
// ============================================================================
module osc_capture_buffer #(
    parameter int SAMPLE_W = 32,
    parameter int CHANNELS = 2,
    parameter int DEPTH    = 160,
    parameter int OUT_MAX  = 60,
    parameter int PRETRIG  = 80,
    parameter int HOLDOFF  = 1666667
) (
    input  wire                 clock,
    input  wire                 reset,
    osc_capture_buffer_if.slave bus,
    input  wire  [2:0]          time_div,
    input  wire  [2:0]          volt_div,
    input  wire  [1:0]          mode,
    input  wire  [15:0]         trig_level,
    input  wire                 trig_slope,
    input  wire                 arm,
    output logic                frame_ready,
    output logic [2:0]          state
);
    localparam int c_ch_w = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int c_aw   = $clog2(DEPTH);
    localparam int c_fw   = $clog2(DEPTH + 1);
    localparam int c_hw   = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
    localparam int c_gw   = $clog2(OUT_MAX + 1) + 1;
    localparam int c_pw   = SAMPLE_W + c_gw + 4;
    localparam int c_sw   = ((c_aw > 8) ? c_aw : 8) + 1;
    localparam int c_post = DEPTH - PRETRIG - 1;
    localparam logic signed [c_gw-1:0] c_gain = c_gw'(OUT_MAX);
    localparam logic [c_aw-1:0]        c_last = c_aw'(DEPTH - 1);

    typedef enum logic [2:0] {
        ST_ROLL  = 3'd0,
        ST_FILL  = 3'd1,
        ST_ARMED = 3'd2,
        ST_POST  = 3'd3,
        ST_HOLD  = 3'd4
    } state_t;

    state_t               state_q, state_d;
    logic [c_aw-1:0]      wptr_q, wptr_d, tpos_q, tpos_d, cnt_q, cnt_d;
    logic [c_fw-1:0]      fill_q, fill_d;
    logic [2:0]           dec_q, dec_d;
    logic [c_hw-1:0]      hold_q, hold_d;
    logic signed [15:0]   prev_q, prev_d;
    logic [DEPTH-1:0]     valid_q, valid_d;
    logic [31:0]          y_q, y_d;
    logic                 ysign_q, ysign_d;
    logic signed [15:0]   mem_q [DEPTH];

    logic signed [SAMPLE_W-1:0] w_sel;
    logic signed [c_pw-1:0]     w_prod;
    logic signed [15:0]         w_scaled, w_level, w_data;
    logic                       w_accept, w_trig, w_wr_en, w_blank;
    logic [c_aw-1:0]            w_start, w_addr;
    logic [c_sw-1:0]            w_sum;
    logic [15:0]                w_mag;

    always_comb begin
        w_sel = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (bus.ch_sel == c_ch_w'(c)) w_sel = bus.sample_in[c*SAMPLE_W +: SAMPLE_W];
        end
    end

    // Full-precision product, then floor division by 2^(SAMPLE_W-1).
    assign w_prod   = w_sel * c_gain * $signed({1'b0, volt_div});
    assign w_scaled = 16'(w_prod >>> (SAMPLE_W - 1));
    assign w_level  = $signed(trig_level);
    assign w_accept = bus.sample_valid && (dec_q >= time_div);
    assign w_wr_en  = w_accept && (state_q != ST_HOLD);
    assign w_trig   = trig_slope ? ((prev_q > w_level) && (w_scaled <= w_level))
                                 : ((prev_q < w_level) && (w_scaled >= w_level));

    always_comb begin
        dec_d   = dec_q;
        wptr_d  = wptr_q;
        fill_d  = fill_q;
        prev_d  = prev_q;
        valid_d = valid_q;
        if (bus.sample_valid) dec_d = w_accept ? 3'd0 : dec_q + 3'd1;
        if (w_accept) prev_d = w_scaled;
        if (w_wr_en) begin
            wptr_d          = (wptr_q == c_last) ? '0 : wptr_q + 1'b1;
            valid_d[wptr_q] = 1'b1;
            if (fill_q != c_fw'(DEPTH)) fill_d = fill_q + 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tpos_d  = tpos_q;
        case (state_q)
            ST_ROLL: begin
                if (mode != 2'd0) begin
                    state_d = ST_FILL;
                    cnt_d   = '0;
                end
            end
            ST_FILL: begin
                if (w_accept) begin
                    if (cnt_q == c_aw'(PRETRIG - 1)) begin
                        state_d = ST_ARMED;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            ST_ARMED: begin
                if (w_accept && w_trig) begin
                    tpos_d  = wptr_q;
                    cnt_d   = '0;
                    state_d = (c_post == 0) ? ST_HOLD : ST_POST;
                end
            end
            ST_POST: begin
                if (w_accept) begin
                    if (cnt_q == c_aw'(c_post - 1)) begin
                        state_d = ST_HOLD;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            ST_HOLD: begin
                if (mode == 2'd1 && hold_q == c_hw'(HOLDOFF - 1)) state_d = ST_FILL;
            end
            default: state_d = ST_ROLL;
        endcase
        // Arm beats a coincident trigger: the trigger address is discarded.
        if (arm && state_q != ST_ROLL) begin
            state_d = ST_FILL;
            cnt_d   = '0;
            tpos_d  = tpos_q;
        end
        if (mode == 2'd0) state_d = ST_ROLL;
        hold_d = (state_q == ST_HOLD && state_d == ST_HOLD) ? hold_q + 1'b1 : '0;
    end

    always_comb begin
        if (state_q == ST_ROLL)            w_start = wptr_q;
        else if (tpos_q >= c_aw'(PRETRIG)) w_start = tpos_q - c_aw'(PRETRIG);
        else                               w_start = tpos_q + c_aw'(DEPTH - PRETRIG);
        w_sum   = c_sw'(w_start) + c_sw'(bus.x);
        w_addr  = (w_sum >= c_sw'(DEPTH)) ? c_aw'(w_sum - c_sw'(DEPTH)) : c_aw'(w_sum);
        w_blank = (c_sw'(bus.x) >= c_sw'(DEPTH))
               || ((state_q == ST_ROLL) && (c_sw'(bus.x) + c_sw'(fill_q) < c_sw'(DEPTH)))
               || !valid_q[w_addr];
        w_data  = mem_q[w_addr];
        w_mag   = w_data[15] ? 16'(-w_data) : w_data;
        y_d     = w_blank ? 32'd0 : {16'd0, w_mag};
        ysign_d = w_blank ? 1'b0 : w_data[15];
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_ROLL;
            wptr_q  <= '0;
            tpos_q  <= '0;
            cnt_q   <= '0;
            fill_q  <= '0;
            dec_q   <= '0;
            hold_q  <= '0;
            prev_q  <= '0;
            valid_q <= '0;
            y_q     <= '0;
            ysign_q <= 1'b0;
        end else begin
            state_q <= state_d;
            wptr_q  <= wptr_d;
            tpos_q  <= tpos_d;
            cnt_q   <= cnt_d;
            fill_q  <= fill_d;
            dec_q   <= dec_d;
            hold_q  <= hold_d;
            prev_q  <= prev_d;
            valid_q <= valid_d;
            y_q     <= y_d;
            ysign_q <= ysign_d;
        end
    end

    always_ff @(posedge clock) begin
        if (w_wr_en) mem_q[wptr_q] <= w_scaled;
    end

    assign bus.y       = y_q;
    assign bus.y_sign  = ysign_q;
    assign state       = state_q;
    assign frame_ready = (state_q == ST_HOLD);
endmodule
`default_nettype wire
